// File: rtl/mem8x8_ctrl.sv
// Sequencer for an 8x8 word array behind a 1-to-8 address demux and a tri-state read buffer.
// Each request runs SETUP (address settle), a single STROBE cycle, and DONE before returning to IDLE.
module mem8x8_ctrl #(
  parameter int SETUP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_adr,
  input  logic [7:0] req_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       mem_sel,
  output logic [2:0] mem_adr,
  output logic       mem_we,
  output logic       mem_oe,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(SETUP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       we_q;
  logic       accept;

  // req_ready is a registered copy of (state == IDLE)
  assign accept = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_LOAD;
        end
      end
      SETUP: begin
        if (cnt == 2'd0) state_nxt = STROBE;
        else             cnt_nxt   = cnt - 2'd1;
      end
      STROBE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are decoded from the next state so every pin comes straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      mem_sel   <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_adr   <= 3'b000;
      mem_wdata <= 8'h00;
      we_q      <= 1'b0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      mem_sel   <= (state_nxt == STROBE);
      mem_we    <= (state_nxt == STROBE) && we_q;
      mem_oe    <= (state_nxt == STROBE) && !we_q;
      rd_valid  <= (state == STROBE) && !we_q;
      if ((state == STROBE) && !we_q) rd_data <= mem_rdata;
      if (accept) begin
        we_q      <= req_we;
        mem_adr   <= req_adr;
        mem_wdata <= req_data;
      end
    end
  end

endmodule

// File: doc/mem8x8_ctrl.md
MEM8X8_CTRL -- requirements
Module: mem8x8_ctrl

Interface
REQ-001 The block SHALL have one parameter: SETUP_CYCLES, default 1, number of address-setup cycles before the strobe (legal 1..4).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = write, 0 = read
- req_adr  input  3  target word address
- req_data  input  8  write data
- rd_valid  output  1  one-cycle pulse, rd_data valid
- rd_data  output  8  last read word
- mem_sel  output  1  strobe to the 1-to-8 address demux input
- mem_adr  output  3  select bus to the demux
- mem_we  output  1  write enable to the word array
- mem_oe  output  1  enable for the read tri-state buffer
- mem_wdata  output  8  write data to the word array
- mem_rdata  input  8  resolved read bus from the tri-state buffer
- busy  output  1  transaction in progress (not IDLE)

Function
REQ-003 The FSM SHALL have states IDLE, SETUP, STROBE and DONE, and only those.
REQ-004 A request SHALL be accepted only on a rising edge where req_valid=1 and req_ready=1.
REQ-005 req_ready SHALL be 1 only in IDLE, and busy SHALL equal not req_ready.
REQ-006 On acceptance the block SHALL latch req_we, req_adr and req_data, then enter SETUP with the setup counter loaded to SETUP_CYCLES-1.
REQ-007 Request inputs SHALL be ignored outside the accepting edge, so changes during a transaction have no effect.
REQ-008 SETUP SHALL last exactly SETUP_CYCLES cycles, with mem_adr driven from the latched address and mem_sel, mem_we and mem_oe held at 0, so the demux decode settles glitch-free.
REQ-009 STROBE SHALL last exactly one cycle with mem_sel=1, mem_adr still held, and the operation as follows:
- write: mem_we=1 and mem_wdata = latched data
- read: mem_oe=1, and mem_rdata is captured into rd_data on the edge that leaves STROBE
REQ-010 DONE SHALL last exactly one cycle with mem_sel, mem_we and mem_oe at 0 and mem_adr held; rd_valid SHALL be 1 in DONE for reads only.
REQ-011 DONE SHALL always go to IDLE, and a request cannot be accepted in DONE.
REQ-012 Timing from an acceptance edge at cycle 0:
- strobe in cycle SETUP_CYCLES+1
- DONE in cycle SETUP_CYCLES+2
- req_ready back to 1 in cycle SETUP_CYCLES+3
- back-to-back throughput: one transaction per SETUP_CYCLES+3 cycles
REQ-013 mem_we and mem_oe SHALL never be 1 in the same cycle, and neither SHALL be 1 outside STROBE.
REQ-014 All outputs SHALL be registered (no combinational path from request inputs to mem_* outputs).
REQ-015 rd_data SHALL hold its value until the next read's STROBE exit edge, and writes SHALL not alter it.
REQ-016 mem_wdata SHALL hold the last latched data when not writing.
REQ-017 Every address 0..7 SHALL be legal, with no wrap or range check needed.

Reset
REQ-018 While rst=1 the block SHALL asynchronously force the following, regardless of clk:
- state to IDLE
- req_ready=1, busy=0, rd_valid=0
- rd_data=8'h00
- mem_sel=0, mem_we=0, mem_oe=0
- mem_adr=3'b000, mem_wdata=8'h00
- setup counter=0
REQ-019 Reset asserted mid-transaction (including during STROBE) SHALL abort it immediately with no completion pulse, and the latched request SHALL be discarded.
REQ-020 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios (SETUP_CYCLES=1 unless stated):
- Write adr=5, data=8'hA7 -> mem_sel=1, mem_we=1, mem_adr=5, mem_wdata=8'hA7 for exactly one cycle in cycle 2; req_ready=1 again in cycle 4.
- Read adr=3 with mem_rdata=8'h3C during STROBE -> mem_oe=1 in cycle 2 only; rd_valid=1 and rd_data=8'h3C in cycle 3; rd_data still 8'h3C after a later write.
- req_valid held high with alternating writes/reads to adr 0..7 -> one acceptance every 4 cycles; mem_we and mem_oe never both 1; req_adr toggled during SETUP has no effect on mem_adr.
- SETUP_CYCLES=4, write adr=7 -> strobe in cycle 5; mem_adr=7 stable from cycle 1 through cycle 6.
- rst pulsed asynchronously during the STROBE of a read -> mem_sel/mem_oe drop without a clock edge; no rd_valid; rd_data=8'h00; req_ready=1.
- Read of adr=0 right after reset with mem_rdata=8'hFF -> rd_data=8'hFF and a single rd_valid pulse.
